// File: rtl/alu_control_seq.sv
// EX-stage ALU operation decoder with an RV32M/RV64M sequencer.
// Base ops decode combinationally; mul/div stall EX until the result is ready.
module alu_control_seq #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int OP_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp,
  input  logic            is_rtype,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [OP_W-1:0] Operation,
  output logic            stall_o,
  output logic [XLEN-1:0] md_result_o,
  output logic            md_valid_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CW   = $clog2(CMAX) + 1;

  state_t state, nxt;

  logic            is_mop, is_shift, issue;
  logic [6:0]      f7;
  logic [3:0]      br_code, rr_code;
  logic            dz, ovf, special;
  logic [XLEN-1:0] spec_res;

  logic [CW-1:0]   cnt;
  logic [1:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            negq_q, negr_q;

  logic              sa, sb;
  logic [2*XLEN-1:0] ea, eb, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   quo_n, rem_n, div_res;
  logic              mul_last, div_last;

  // I-type only carries Funct7 for shifts (it is imm[11:5] otherwise)
  assign is_shift = (Funct3 == 3'b001) || (Funct3 == 3'b101);
  assign f7       = (is_rtype || is_shift) ? Funct7 : 7'b0;
  assign is_mop   = (ALUOp == 2'b10) && is_rtype && (Funct7 == 7'b0000001);

  always_comb begin
    br_code = 4'b0011;
    unique case (Funct3)
      3'b000:  br_code = 4'b1000;
      3'b001:  br_code = 4'b0100;
      3'b100:  br_code = 4'b0101;
      3'b101:  br_code = 4'b0110;
      default: br_code = 4'b0011;
    endcase
  end

  always_comb begin
    rr_code = 4'b0011;
    unique case (Funct3)
      3'b000:  rr_code = (is_rtype && f7 == 7'b0100000) ? 4'b1001 : 4'b0011;
      3'b001:  rr_code = 4'b1100;
      3'b010:  rr_code = 4'b0111;
      3'b100:  rr_code = 4'b0010;
      3'b101:  rr_code = (f7 == 7'b0100000) ? 4'b1010 : 4'b1011;
      3'b110:  rr_code = 4'b0001;
      3'b111:  rr_code = 4'b0000;
      default: rr_code = 4'b0011;
    endcase
  end

  always_comb begin
    Operation = OP_W'({1'b0, 4'b0011});
    unique case (1'b1)
      is_mop:                       Operation = OP_W'({2'b10, Funct3});
      ALUOp == 2'b01:               Operation = OP_W'({1'b0, br_code});
      ALUOp == 2'b10 && !is_mop:    Operation = OP_W'({1'b0, rr_code});
      default:                      Operation = OP_W'({1'b0, 4'b0011});
    endcase
  end

  assign dz  = (b_i == '0);
  assign ovf = !Funct3[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  assign special = Funct3[2] && (dz || ovf);
  always_comb begin
    spec_res = '0;
    if (Funct3[1]) spec_res = dz ? a_i : '0;
    else           spec_res = dz ? '1 : a_i;
  end

  assign issue = rst_n && (state == IDLE) && valid_i && is_mop && !flush_i;

  // Sign-extend to 2*XLEN so the truncated product is exact for every variant
  assign sa      = (f3_q != 2'b11) & a_q[XLEN-1];
  assign sb      = !f3_q[1] & b_q[XLEN-1];
  assign ea      = {{XLEN{sa}}, a_q};
  assign eb      = {{XLEN{sb}}, b_q};
  assign prod    = ea * eb;
  assign mul_res = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring divider: quo_q shifts the dividend out and quotient bits in
  assign trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign quo_n   = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign rem_n   = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]}
                               : trial[XLEN-1:0];
  assign div_res = f3_q[1] ? (negr_q ? -rem_n : rem_n)
                           : (negq_q ? -quo_n : quo_n);

  assign mul_last = (cnt == CW'(MUL_LAT - 1));
  assign div_last = (cnt == CW'(XLEN - 1));

  always_comb begin
    nxt        = state;
    stall_o    = 1'b0;
    md_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          stall_o = 1'b1;
          if (!Funct3[2])   nxt = MUL;
          else if (special) nxt = DONE;
          else              nxt = DIV;
        end
      end
      MUL: begin
        stall_o = !flush_i;
        if (flush_i)       nxt = IDLE;
        else if (mul_last) nxt = DONE;
      end
      DIV: begin
        stall_o = !flush_i;
        if (flush_i)       nxt = IDLE;
        else if (div_last) nxt = DONE;
      end
      DONE: begin
        md_valid_o = !flush_i;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      f3_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      md_result_o <= '0;
    end else if (issue) begin
      cnt    <= '0;
      f3_q   <= Funct3[1:0];
      a_q    <= a_i;
      b_q    <= b_i;
      rem_q  <= '0;
      quo_q  <= (!Funct3[0] && a_i[XLEN-1]) ? -a_i : a_i;
      dvs_q  <= (!Funct3[0] && b_i[XLEN-1]) ? -b_i : b_i;
      negq_q <= !Funct3[0] && (a_i[XLEN-1] ^ b_i[XLEN-1]);
      negr_q <= !Funct3[0] && a_i[XLEN-1];
      if (special) md_result_o <= spec_res;
    end else if (state == MUL && !flush_i) begin
      cnt <= cnt + 1'b1;
      if (mul_last) md_result_o <= mul_res;
    end else if (state == DIV && !flush_i) begin
      cnt   <= cnt + 1'b1;
      quo_q <= quo_n;
      rem_q <= rem_n;
      if (div_last) md_result_o <= div_res;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: directed decode and M-op vectors.
// Issue pushes expectations; a negedge monitor pops them on md_valid_o.
module tb_alu_control_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, flush_i, is_rtype;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] a_i, b_i;
  logic [4:0]  Operation;
  logic        stall_o, md_valid_o;
  logic [31:0] md_result_o;

  alu_control_seq #(.XLEN(32), .MUL_LAT(2), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .is_rtype(is_rtype), .Funct7(Funct7), .Funct3(Funct3),
    .a_i(a_i), .b_i(b_i), .Operation(Operation), .stall_o(stall_o),
    .md_result_o(md_result_o), .md_valid_o(md_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          stalls;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   stall_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (md_valid_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_md_valid: got result %h with empty queue",
                 md_result_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.nm, "_result"}, md_result_o, e.res);
        chk({e.nm, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
      end
      stall_cnt = 0;
    end else if (stall_o) begin
      stall_cnt++;
    end else begin
      stall_cnt = 0;
    end
  end

  task automatic dec(input string nm, input logic [1:0] op, input logic rt,
                     input logic [6:0] f7, input logic [2:0] f3,
                     input logic [4:0] exp);
    ALUOp = op; is_rtype = rt; Funct7 = f7; Funct3 = f3; valid_i = 1'b1;
    #1;
    chk({nm, "_op"}, 32'(Operation), 32'(exp));
    chk({nm, "_stall"}, 32'(stall_o), 32'd0);
    valid_i = 1'b0;
  endtask

  task automatic set_mop(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
    ALUOp = 2'b10; is_rtype = 1'b1; Funct7 = 7'b0000001; Funct3 = f3;
    a_i = a; b_i = b; valid_i = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!stall_o) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got stall_o stuck high expected release", nm);
    end
  endtask

  task automatic mop(input string nm, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int stalls);
    exp_t e;
    e.res = res; e.stalls = stalls; e.nm = nm;
    @(posedge clk); #1;
    sbq.push_back(e);
    set_mop(f3, a, b);
    wait_done(nm);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; is_rtype = 1'b0;
    ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_valid", 32'(md_valid_o), 32'd0);
    chk("reset_result", md_result_o, 32'd0);
    rst_n = 1'b1;

    dec("addi_neg", 2'b10, 1'b0, 7'b0100000, 3'b000, 5'b00011);
    dec("sub",      2'b10, 1'b1, 7'b0100000, 3'b000, 5'b01001);
    dec("add",      2'b10, 1'b1, 7'b0000000, 3'b000, 5'b00011);
    dec("srai_i",   2'b10, 1'b0, 7'b0100000, 3'b101, 5'b01010);
    dec("srli",     2'b10, 1'b1, 7'b0000000, 3'b101, 5'b01011);
    dec("slli",     2'b10, 1'b0, 7'b0000000, 3'b001, 5'b01100);
    dec("and",      2'b10, 1'b1, 7'b0000000, 3'b111, 5'b00000);
    dec("or",       2'b10, 1'b1, 7'b0000000, 3'b110, 5'b00001);
    dec("xor",      2'b10, 1'b0, 7'b0000000, 3'b100, 5'b00010);
    dec("slti",     2'b10, 1'b0, 7'b1111111, 3'b010, 5'b00111);
    dec("sltu",     2'b10, 1'b1, 7'b0000000, 3'b011, 5'b00011);
    dec("bne",      2'b01, 1'b0, 7'b0000000, 3'b001, 5'b00100);
    dec("blt",      2'b01, 1'b0, 7'b0000000, 3'b100, 5'b00101);
    dec("bge",      2'b01, 1'b0, 7'b0000000, 3'b101, 5'b00110);
    dec("jal",      2'b11, 1'b0, 7'b0000000, 3'b111, 5'b00011);
    dec("lw",       2'b00, 1'b0, 7'b0100000, 3'b010, 5'b00011);

    ALUOp = 2'b10; is_rtype = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b100;
    valid_i = 1'b0;
    #1;
    chk("mop_div_op", 32'(Operation), 32'(5'b10100));
    chk("mop_noissue_stall", 32'(stall_o), 32'd0);

    mop("mul",    3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 3);
    mop("mulhu",  3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 3);
    mop("mulh",   3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 3);
    mop("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 3);
    mop("mulhu_big", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 3);
    mop("div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    mop("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    mop("remu",   3'b111, 32'd7, 32'd2, 32'd1, 33);
    mop("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33);
    mop("div_pos_neg", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    mop("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    mop("rem_z",  3'b110, 32'd5, 32'd0, 32'd5, 1);
    mop("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    mop("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    @(posedge clk); #1;
    set_mop(3'b100, 32'd100, 32'd3);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_valid", 32'(md_valid_o), 32'd0);
    mop("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 3);

    @(posedge clk); #1;
    set_mop(3'b100, 32'hFFFFFFF9, 32'd2);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_valid", 32'(md_valid_o), 32'd0);
    chk("arst_result", md_result_o, 32'd0);
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dec("beq", 2'b01, 1'b0, 7'b0000000, 3'b000, 5'b01000);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
